axi4_lite_read_master: RTL

// - AXI4-Lite read master; the CPU load path's interface to the read slaves on the bus.
// - Accepts one load request (address) from the core and issues an AR beat.
// - Accepts the R beat, then returns the data plus response status to the core.
// - One outstanding read at a time; no request queue.
// - A watchdog flags reads that stall too long. It is a status flag only; it never aborts the transaction.

---
 rtl/axi4_lite_pkg.sv | 28 ++
 rtl/axi4_lite_read_master.sv | 135 +++++++++++++
 2 files changed

// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package    : axi4_lite_pkg                                         |
// | Description: AXI4-Lite response codes and master state encodings  |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } m_axi_read_states;

    // EXOKAY counts as an error: a plain load never requests exclusive access.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != OKAY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_read_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : axi4_lite_read_master                                 |
// | Description: single-outstanding AXI4-Lite read master with a       |
// |              status-only stall watchdog                            |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module axi4_lite_read_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_read,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  read_busy,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_done,
    output logic                  read_error,
    output logic                  read_timeout,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] WDOG_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] WDOG_ONE   = TW'(1);

    m_axi_read_states        state_q, state_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
    logic                    read_error_q, read_error_d;
    logic                    read_done_q, read_done_d;
    logic                    read_timeout_q, read_timeout_d;
    logic [TW-1:0]           wdog_q, wdog_d;

    logic w_start;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_busy;

    assign w_busy  = (state_q != ST_IDLE);
    assign w_start = (state_q == ST_IDLE) && start_read;
    assign w_ar_hs = (state_q == ST_ADDR) && M_AXI_ARREADY;
    assign w_r_hs  = (state_q == ST_DATA) && M_AXI_RVALID;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_start) state_d = ST_ADDR;
            ST_ADDR: if (w_ar_hs) state_d = ST_DATA;
            ST_DATA: if (w_r_hs)  state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address latch, R capture and watchdog
    always_comb begin
        araddr_d       = araddr_q;
        read_data_d    = read_data_q;
        read_error_d   = read_error_q;
        read_done_d    = 1'b0;
        read_timeout_d = read_timeout_q;
        wdog_d         = wdog_q;

        if (w_start) begin
            araddr_d       = read_addr;
            read_timeout_d = 1'b0;
            wdog_d         = '0;
        end

        if (w_r_hs) begin
            read_data_d  = M_AXI_RDATA;
            read_error_d = resp_is_error(M_AXI_RRESP);
            read_done_d  = 1'b1;
        end

        // Saturating count; the flag only reports, the FSM keeps waiting.
        if (w_busy) begin
            if (wdog_q != WDOG_LIMIT) begin
                wdog_d = wdog_q + WDOG_ONE;
            end
            if (wdog_d == WDOG_LIMIT) begin
                read_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            araddr_q       <= '0;
            read_data_q    <= '0;
            read_error_q   <= 1'b0;
            read_done_q    <= 1'b0;
            read_timeout_q <= 1'b0;
            wdog_q         <= '0;
        end else begin
            araddr_q       <= araddr_d;
            read_data_q    <= read_data_d;
            read_error_q   <= read_error_d;
            read_done_q    <= read_done_d;
            read_timeout_q <= read_timeout_d;
            wdog_q         <= wdog_d;
        end
    end

    // Handshake outputs decode the state flop so reset drops them at once.
    assign read_busy     = w_busy;
    assign M_AXI_ARVALID = (state_q == ST_ADDR);
    assign M_AXI_RREADY  = (state_q == ST_DATA);
    assign M_AXI_ARADDR  = araddr_q;
    assign read_data     = read_data_q;
    assign read_error    = read_error_q;
    assign read_done     = read_done_q;
    assign read_timeout  = read_timeout_q;

endmodule
`default_nettype wire
